// File: rtl/bus_pkg.sv
// bus_pkg: FSM state type and sizing constants shared by the read and write sides
// of the half-duplex tri-state bus.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_CAPT = 2'd2,
    ST_HOLD = 2'd3
  } bus_rx_state_t;

  localparam int unsigned TURN_MAX  = 7;
  localparam int unsigned BEATS_MAX = 16;

  // One spare bit so a counter reaching its maximum can never wrap.
  localparam int unsigned TURN_CNT_W = $clog2(TURN_MAX) + 1;
  localparam int unsigned BEAT_CNT_W = $clog2(BEATS_MAX) + 1;

endpackage

// File: rtl/bus_rx_capt.sv
// bus_rx_capt: beat-indexed capture register file; the slot selected by wr_idx_i
// takes wr_data_i when wr_en_i is high, every other slot keeps its value.
module bus_rx_capt
  import bus_pkg::*;
#(
  parameter int unsigned DATAW = 4,
  parameter int unsigned BEATS = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en_i,
  input  logic [BEAT_CNT_W-1:0]  wr_idx_i,
  input  logic [DATAW-1:0]       wr_data_i,
  output logic [BEATS*DATAW-1:0] data_o
);

  logic [BEATS*DATAW-1:0] data_q;
  logic [BEATS*DATAW-1:0] data_d;

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < BEATS; i++) begin
      if (wr_en_i && (wr_idx_i == BEAT_CNT_W'(i))) begin
        data_d[i*DATAW +: DATAW] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bus_rx.sv
// bus_rx: read side of a half-duplex tri-state bus. Grants the far end, waits out the
// turnaround, captures BEATS beats and holds them. `BUS_PARITY_EN adds per-beat parity.
module bus_rx
  import bus_pkg::*;
#(
  parameter int unsigned DATAW = 4,
  parameter int unsigned TURN  = 2,
  parameter int unsigned BEATS = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATAW-1:0]       bus_in,
  output logic                   own_en,
  output logic                   peer_en,
  output logic                   rd_valid,
  input  logic                   rd_ready,
`ifdef BUS_PARITY_EN
  input  logic                   bus_par,
  output logic                   rd_err,
`endif
  output logic [BEATS*DATAW-1:0] rd_data
);

  bus_rx_state_t           state_q, state_d;
  logic [TURN_CNT_W-1:0]   turnCnt_q, turnCnt_d;
  logic [BEAT_CNT_W-1:0]   beatCnt_q, beatCnt_d;
  logic                    captEn;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      turnCnt_q <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      turnCnt_q <= turnCnt_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    turnCnt_d = turnCnt_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_TURN;
          turnCnt_d = TURN_CNT_W'(TURN - 1);
          beatCnt_d = '0;
        end
      end
      ST_TURN: begin
        if (turnCnt_q == '0) begin
          state_d   = ST_CAPT;
          beatCnt_d = '0;
        end else begin
          turnCnt_d = turnCnt_q - 1'b1;
        end
      end
      ST_CAPT: begin
        beatCnt_d = beatCnt_q + 1'b1;
        if (beatCnt_q == BEAT_CNT_W'(BEATS - 1)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rd_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from the state register only; peer_en falls with the move into HOLD.
  always_comb begin
    req_ready = 1'b0;
    peer_en   = 1'b0;
    rd_valid  = 1'b0;
    captEn    = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_TURN: peer_en   = 1'b1;
      ST_CAPT: begin
        peer_en = 1'b1;
        captEn  = 1'b1;
      end
      ST_HOLD: rd_valid  = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign own_en = 1'b0;

  bus_rx_capt #(
    .DATAW (DATAW),
    .BEATS (BEATS)
  ) u_capt (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (captEn),
    .wr_idx_i  (beatCnt_q),
    .wr_data_i (bus_in),
    .data_o    (rd_data)
  );

`ifdef BUS_PARITY_EN
  logic err_q, err_d;

  // Sticky across one transaction's beats; cleared when the next request is accepted.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && req_valid) begin
      err_d = 1'b0;
    end else if (captEn && (^{bus_par, bus_in})) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rd_err = err_q && (state_q == ST_HOLD);
`endif

endmodule

// File: tb/tb_bus_rx.sv
// tb_bus_rx: randomized read transactions against a beat-schedule reference model,
// plus directed reset, backpressure and back-to-back request cases.
module tb_bus_rx;

  localparam int unsigned DATAW = 4;
  localparam int unsigned TURN  = 2;
  localparam int unsigned BEATS = 2;
  localparam int unsigned RDW   = BEATS * DATAW;

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             req_valid = 1'b0;
  logic             rd_ready  = 1'b0;
  logic [DATAW-1:0] bus_in    = '0;
  logic             req_ready;
  logic             own_en;
  logic             peer_en;
  logic             rd_valid;
  logic [RDW-1:0]   rd_data;
`ifdef BUS_PARITY_EN
  logic             bus_par = 1'b0;
  logic             rd_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATAW-1:0] curBeats [BEATS];
  logic             curPar   [BEATS];

  always #5 clk = ~clk;

  bus_rx #(
    .DATAW (DATAW),
    .TURN  (TURN),
    .BEATS (BEATS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .bus_in    (bus_in),
    .own_en    (own_en),
    .peer_en   (peer_en),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
`ifdef BUS_PARITY_EN
    .bus_par   (bus_par),
    .rd_err    (rd_err),
`endif
    .rd_data   (rd_data)
  );

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomBeats(input bit cleanParity);
    for (int j = 0; j < BEATS; j++) begin
      curBeats[j] = DATAW'($urandom);
      curPar[j]   = cleanParity ? ^curBeats[j] : 1'($urandom);
    end
  endtask

  // One read: beat j must be on the bus in the (TURN+1+j)-th cycle with peer_en high.
  task automatic applyStimulus(input bit keepReq, input int holdCycles);
    logic [RDW-1:0] expData;
    logic           expErr;
    expData = '0;
    expErr  = 1'b0;
    for (int j = 0; j < BEATS; j++) begin
      expData = expData | (RDW'(curBeats[j]) << (j * DATAW));
      expErr  = expErr | (^{curPar[j], curBeats[j]});
    end
    req_valid = 1'b1;
    for (int i = 0; i < TURN + BEATS; i++) begin
      stepCycle();
      if (!keepReq) req_valid = 1'($urandom);
      checkOutput("peer_en_busy", 32'(peer_en), 32'd1);
      checkOutput("rd_valid_early", 32'(rd_valid), 32'd0);
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      checkOutput("own_en", 32'(own_en), 32'd0);
      rd_ready = 1'($urandom);
      if (i >= TURN) begin
        bus_in = curBeats[i-TURN];
`ifdef BUS_PARITY_EN
        bus_par = curPar[i-TURN];
`endif
      end else begin
        bus_in = DATAW'($urandom);
`ifdef BUS_PARITY_EN
        bus_par = 1'($urandom);
`endif
      end
    end
    stepCycle();
    rd_ready = 1'b0;
    checkOutput("rd_valid_rise", 32'(rd_valid), 32'd1);
    checkOutput("peer_en_drop", 32'(peer_en), 32'd0);
    checkOutput("rd_data", 32'(rd_data), 32'(expData));
    checkOutput("own_en_hold", 32'(own_en), 32'd0);
`ifdef BUS_PARITY_EN
    checkOutput("rd_err", 32'(rd_err), 32'(expErr));
`endif
    for (int h = 0; h < holdCycles; h++) begin
      bus_in = DATAW'($urandom);
      stepCycle();
      checkOutput("rd_valid_hold", 32'(rd_valid), 32'd1);
      checkOutput("rd_data_hold", 32'(rd_data), 32'(expData));
    end
    rd_ready = 1'b1;
    stepCycle();
    rd_ready  = 1'b0;
    req_valid = keepReq;
    checkOutput("rd_valid_fall", 32'(rd_valid), 32'd0);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    checkOutput("peer_en_idle", 32'(peer_en), 32'd0);
  endtask

  initial begin
    stepCycle();
    stepCycle();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_peer_en", 32'(peer_en), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h00);
    checkOutput("rst_own_en", 32'(own_en), 32'd0);
    rstn = 1'b1;
    stepCycle();

    // Basic read with backpressure while bus_in keeps changing.
    curBeats[0] = 4'b1101;
    curBeats[1] = 4'b0110;
    curPar[0]   = 1'b1;
    curPar[1]   = 1'b0;
    applyStimulus(1'b0, 3);

    // Reset in CAPT right after beat 0 was sampled.
    randomBeats(1'b1);
    req_valid = 1'b1;
    for (int i = 0; i <= TURN; i++) begin
      stepCycle();
      req_valid = 1'b0;
    end
    bus_in = 4'hA;
    stepCycle();
    checkOutput("capt_peer_en", 32'(peer_en), 32'd1);
    rstn = 1'b0;
    for (int r = 0; r < 2; r++) begin
      stepCycle();
      checkOutput("midrst_peer_en", 32'(peer_en), 32'd0);
      checkOutput("midrst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("midrst_rd_data", 32'(rd_data), 32'h00);
    end
    rstn = 1'b1;
    for (int r = 0; r < 3; r++) begin
      stepCycle();
      checkOutput("postrst_rd_valid", 32'(rd_valid), 32'd0);
    end
    applyStimulus(1'b0, 0);

    // req_valid held high: one IDLE cycle between consecutive reads.
    for (int t = 0; t < 4; t++) begin
      randomBeats(1'b1);
      applyStimulus(1'b1, 0);
    end
    req_valid = 1'b0;
    stepCycle();

`ifdef BUS_PARITY_EN
    curBeats[0] = 4'b1101;
    curBeats[1] = 4'b0110;
    curPar[0]   = 1'b1;
    curPar[1]   = 1'b1;
    applyStimulus(1'b0, 1);
    randomBeats(1'b1);
    applyStimulus(1'b0, 0);
`endif

    for (int t = 0; t < 20; t++) begin
      randomBeats(1'($urandom));
      applyStimulus(1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
